// File: rtl/vga_stream_pkg.sv
// Shared types and sizes for the VGA pixel-stream blocks.
package vga_stream_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } demux_state_t;

  localparam int unsigned PIX_W_DEFAULT = 3;
  localparam int unsigned SWITCH_CNT_W  = 16;

  // Saturating increment for event counters.
  function automatic logic [SWITCH_CNT_W-1:0] sat_inc(input logic [SWITCH_CNT_W-1:0] v);
    return (&v) ? v : v + SWITCH_CNT_W'(1);
  endfunction

endpackage

// File: rtl/stream_reg.sv
// Single-slot valid/ready pipeline register: 1-cycle latency, full throughput.
module stream_reg #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready
);

  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;

  // Slot may refill in the same cycle it is being consumed.
  assign s_ready = !hold_valid || m_ready;
  assign m_valid = hold_valid;
  assign m_data  = hold_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (s_valid && s_ready) begin
      hold_valid <= 1'b1;
      hold_data  <= s_data;
    end else if (m_ready) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1_2.sv
// Registered 1:2 pixel-stream demux; destination changes only at frame starts after the slot drains.
// Optional switch counter port: define STREAM_DEMUX_SWITCH_CNT_EN.
module stream_demux_1_2
  import vga_stream_pkg::*;
#(
  parameter int unsigned WIDTH    = PIX_W_DEFAULT,
  parameter logic        SEL_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel_req,
  input  logic             frame_start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out0_valid,
  output logic [WIDTH-1:0] out0_data,
  input  logic             out0_ready,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out1_data,
  input  logic             out1_ready,
  output logic             sel_active,
  output logic             switching
`ifdef STREAM_DEMUX_SWITCH_CNT_EN
  ,
  output logic [SWITCH_CNT_W-1:0] switch_cnt
`endif
);

  demux_state_t     state_q, state_d;
  logic             sel_active_q, sel_active_d;
  logic             sel_pend_q, sel_pend_d;
  logic             switch_evt;
  logic             active_ready;
  logic             slot_ready;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;

  assign active_ready = sel_active_q ? out1_ready : out0_ready;

  stream_reg #(.WIDTH(WIDTH)) u_slot (
    .clk     (clk),
    .reset   (reset),
    .s_valid (in_valid && (state_q == RUN)),
    .s_data  (in_data),
    .s_ready (slot_ready),
    .m_valid (hold_valid),
    .m_data  (hold_data),
    .m_ready (active_ready)
  );

  assign in_ready   = !reset && (state_q == RUN) && slot_ready;
  assign out0_valid = hold_valid && !sel_active_q;
  assign out1_valid = hold_valid && sel_active_q;
  assign out0_data  = sel_active_q ? '0 : hold_data;
  assign out1_data  = sel_active_q ? hold_data : '0;
  assign sel_active = sel_active_q;
  assign switching  = (state_q == DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      sel_active_q <= SEL_INIT;
      sel_pend_q   <= SEL_INIT;
    end else begin
      state_q      <= state_d;
      sel_active_q <= sel_active_d;
      sel_pend_q   <= sel_pend_d;
    end
  end

  // A repeat request matching the current sink aborts the drain before the slot empties.
  always_comb begin
    state_d      = state_q;
    sel_active_d = sel_active_q;
    sel_pend_d   = sel_pend_q;
    switch_evt   = 1'b0;
    case (state_q)
      RUN: begin
        if (frame_start && (sel_req != sel_active_q)) begin
          state_d    = DRAIN;
          sel_pend_d = sel_req;
        end
      end
      DRAIN: begin
        if (frame_start) begin
          sel_pend_d = sel_req;
        end
        if (frame_start && (sel_req == sel_active_q)) begin
          state_d = RUN;
        end else if (!hold_valid || active_ready) begin
          state_d      = RUN;
          sel_active_d = sel_pend_d;
          switch_evt   = (sel_pend_d != sel_active_q);
        end
      end
      default: state_d = RUN;
    endcase
  end

`ifdef STREAM_DEMUX_SWITCH_CNT_EN
  logic [SWITCH_CNT_W-1:0] switch_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      switch_cnt_q <= '0;
    end else if (switch_evt) begin
      switch_cnt_q <= sat_inc(switch_cnt_q);
    end
  end

  assign switch_cnt = switch_cnt_q;
`else
  logic unused_switch_evt;
  assign unused_switch_evt = switch_evt;
`endif

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Directed table-driven bench for stream_demux_1_2 (counter checks when STREAM_DEMUX_SWITCH_CNT_EN is defined).
module tb_stream_demux_1_2;

  localparam int unsigned W = 3;
  localparam int unsigned NVEC = 20;

  logic         clk;
  logic         reset;
  logic         sel_req;
  logic         frame_start;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out0_valid;
  logic [W-1:0] out0_data;
  logic         out0_ready;
  logic         out1_valid;
  logic [W-1:0] out1_data;
  logic         out1_ready;
  logic         sel_active;
  logic         switching;
`ifdef STREAM_DEMUX_SWITCH_CNT_EN
  logic [15:0]  switch_cnt;
`endif

  int checks;
  int failures;

  stream_demux_1_2 #(.WIDTH(W), .SEL_INIT(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .sel_req     (sel_req),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out0_valid  (out0_valid),
    .out0_data   (out0_data),
    .out0_ready  (out0_ready),
    .out1_valid  (out1_valid),
    .out1_data   (out1_data),
    .out1_ready  (out1_ready),
    .sel_active  (sel_active),
    .switching   (switching)
`ifdef STREAM_DEMUX_SWITCH_CNT_EN
    ,
    .switch_cnt  (switch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         fs;
    logic         rq;
    logic         iv;
    logic [W-1:0] d;
    logic         r0;
    logic         r1;
    logic         e_rdy;
    logic         e_v0;
    logic [W-1:0] e_d0;
    logic         e_v1;
    logic [W-1:0] e_d1;
    logic         e_sel;
    logic         e_sw;
  } vec_t;

  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fs, input logic rq, input logic iv, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    frame_start = fs;
    sel_req     = rq;
    in_valid    = iv;
    in_data     = d;
    out0_ready  = r0;
    out1_ready  = r1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

`ifdef STREAM_DEMUX_SWITCH_CNT_EN
  // Frame start with an empty slot: one cycle into DRAIN, next cycle back to RUN on the new sink.
  task automatic do_switch(input logic rq);
    drive(1'b1, rq, 1'b0, 3'b000, 1'b1, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
    next_cycle();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;

    //           fs rq iv d       r0 r1  rdy v0 d0      v1 d1      sel sw
    tbl[0]  = '{1'b0,1'b0,1'b1,3'b101,1'b1,1'b0, 1'b1,1'b0,3'b000,1'b0,3'b000,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b1,3'b011,1'b1,1'b0, 1'b1,1'b1,3'b101,1'b0,3'b000,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,3'b010,1'b1,1'b0, 1'b1,1'b1,3'b011,1'b0,3'b000,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b1,3'b110,1'b1,1'b0, 1'b1,1'b1,3'b010,1'b0,3'b000,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b1,3'b111,1'b0,1'b0, 1'b0,1'b1,3'b110,1'b0,3'b000,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,1'b1,3'b111,1'b0,1'b0, 1'b0,1'b1,3'b110,1'b0,3'b000,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b0,1'b1,3'b111,1'b0,1'b0, 1'b0,1'b1,3'b110,1'b0,3'b000,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b1,3'b111,1'b0,1'b0, 1'b0,1'b1,3'b110,1'b0,3'b000,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,3'b000,1'b1,1'b0, 1'b1,1'b1,3'b110,1'b0,3'b000,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,3'b000,1'b1,1'b0, 1'b1,1'b0,3'b110,1'b0,3'b000,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b1,3'b001,1'b0,1'b0, 1'b1,1'b0,3'b110,1'b0,3'b000,1'b0,1'b0};
    tbl[11] = '{1'b1,1'b1,1'b1,3'b100,1'b0,1'b0, 1'b0,1'b1,3'b001,1'b0,3'b000,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b1,3'b100,1'b0,1'b0, 1'b0,1'b1,3'b001,1'b0,3'b000,1'b0,1'b1};
    tbl[13] = '{1'b0,1'b0,1'b1,3'b100,1'b0,1'b0, 1'b0,1'b1,3'b001,1'b0,3'b000,1'b0,1'b1};
    tbl[14] = '{1'b0,1'b0,1'b1,3'b100,1'b1,1'b0, 1'b0,1'b1,3'b001,1'b0,3'b000,1'b0,1'b1};
    tbl[15] = '{1'b0,1'b0,1'b1,3'b100,1'b0,1'b1, 1'b1,1'b0,3'b000,1'b0,3'b001,1'b1,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,3'b000,1'b0,1'b1, 1'b1,1'b0,3'b000,1'b1,3'b100,1'b1,1'b0};
    tbl[17] = '{1'b1,1'b0,1'b0,3'b000,1'b0,1'b1, 1'b1,1'b0,3'b000,1'b0,3'b100,1'b1,1'b0};
    tbl[18] = '{1'b1,1'b1,1'b0,3'b000,1'b0,1'b1, 1'b0,1'b0,3'b000,1'b0,3'b100,1'b1,1'b1};
    tbl[19] = '{1'b0,1'b0,1'b0,3'b000,1'b0,1'b1, 1'b1,1'b0,3'b000,1'b0,3'b100,1'b1,1'b0};

    // Reset state while reset is held
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1);
    #2;
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data",  32'(out0_data),  32'd0);
    chk("rst_out1_data",  32'(out1_data),  32'd0);
    chk("rst_sel_active", 32'(sel_active), 32'd0);
    chk("rst_switching",  32'(switching),  32'd0);
`ifdef STREAM_DEMUX_SWITCH_CNT_EN
    chk("rst_switch_cnt", 32'(switch_cnt), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    next_cycle();

    // Streaming, backpressure, switch with drain, aborted switch
    for (int i = 0; i < int'(NVEC); i++) begin
      drive(tbl[i].fs, tbl[i].rq, tbl[i].iv, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #3;
      chk($sformatf("v%0d_in_ready", i),   32'(in_ready),   32'(tbl[i].e_rdy));
      chk($sformatf("v%0d_out0_valid", i), 32'(out0_valid), 32'(tbl[i].e_v0));
      chk($sformatf("v%0d_out0_data", i),  32'(out0_data),  32'(tbl[i].e_d0));
      chk($sformatf("v%0d_out1_valid", i), 32'(out1_valid), 32'(tbl[i].e_v1));
      chk($sformatf("v%0d_out1_data", i),  32'(out1_data),  32'(tbl[i].e_d1));
      chk($sformatf("v%0d_sel_active", i), 32'(sel_active), 32'(tbl[i].e_sel));
      chk($sformatf("v%0d_switching", i),  32'(switching),  32'(tbl[i].e_sw));
      next_cycle();
    end
`ifdef STREAM_DEMUX_SWITCH_CNT_EN
    chk("cnt_after_table", 32'(switch_cnt), 32'd1);
`endif

    // Reset in the middle of a drain discards the held beat
    drive(1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b0);
    #3;
    chk("rd_accept", 32'(in_ready), 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    #3;
    chk("rd_out1_valid", 32'(out1_valid), 32'd1);
    chk("rd_out1_data",  32'(out1_data),  32'd3);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    #3;
    chk("rd_draining",   32'(switching),  32'd1);
    chk("rd_held",       32'(out1_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rd_rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rd_rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rd_rst_sel_active", 32'(sel_active), 32'd0);
    chk("rd_rst_switching",  32'(switching),  32'd0);
    chk("rd_rst_in_ready",   32'(in_ready),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      chk($sformatf("rd_post%0d_out0_valid", k), 32'(out0_valid), 32'd0);
      chk($sformatf("rd_post%0d_out1_valid", k), 32'(out1_valid), 32'd0);
      chk($sformatf("rd_post%0d_sel_active", k), 32'(sel_active), 32'd0);
    end

`ifdef STREAM_DEMUX_SWITCH_CNT_EN
    // Counter: three switches, then saturation
    chk("cnt_after_reset", 32'(switch_cnt), 32'd0);
    do_switch(1'b1);
    do_switch(1'b0);
    do_switch(1'b1);
    chk("cnt_three",       32'(switch_cnt), 32'd3);
    chk("cnt_three_sel",   32'(sel_active), 32'd1);
    force dut.switch_cnt_q = 16'hFFFF;
    next_cycle();
    release dut.switch_cnt_q;
    do_switch(1'b0);
    chk("cnt_saturated",   32'(switch_cnt), 32'h0000FFFF);
    chk("cnt_sat_sel",     32'(sel_active), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_2.md
Name: stream_demux_1_2

Overview:
- Registered 1-to-2 pixel-stream demultiplexer: the fan-out counterpart of the colour-source 2:1 mux in the VGA datapath.
- Routes one valid/ready pixel stream to one of two sinks, e.g. display path vs. frame capture.
- Destination changes are honoured only at frame boundaries, and only after in-flight data drains, so no frame is split across sinks.

Parameters:
- WIDTH, 3, pixel data width in bits (one bit per R/G/B).
- SEL_INIT, 0, destination selected out of reset (0 = out0, 1 = out1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- sel_req  input  1  requested destination; sampled only when frame_start=1.
- frame_start  input  1  single-cycle pulse at first pixel of a frame.
- in_valid  input  1  input beat valid.
- in_data  input  WIDTH  input pixel.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- out0_valid  output  1  beat valid toward sink 0.
- out0_data  output  WIDTH  pixel to sink 0; 0 when sink 0 is inactive.
- out0_ready  input  1  sink 0 accepts.
- out1_valid  output  1  beat valid toward sink 1.
- out1_data  output  WIDTH  pixel to sink 1; 0 when sink 1 is inactive.
- out1_ready  input  1  sink 1 accepts.
- sel_active  output  1  destination currently in use.
- switching  output  1  high while in DRAIN.

Behaviour:
- Reset (async, active-high):
  - state=RUN, sel_active=SEL_INIT, sel_pend=SEL_INIT.
  - Slot empty (hold_valid=0), hold_data=0.
  - All out*_valid=0, out*_data=0, switching=0, in_ready=0 while reset asserted.
- Single-slot pipeline register:
  - in->out latency is exactly 1 cycle.
  - Full throughput (1 beat/clk) when the active sink holds ready=1.
- Active sink:
  - outN_valid = hold_valid & (sel_active==N).
  - outN_data = hold_data when N active, else 0.
  - Inactive sink's valid is always 0.
- in_ready = (state==RUN) & (!hold_valid | active_ready). Combinational from active ready; no combinational path from in_valid to any output.
- Slot update:
  - Accept: hold loads in_data.
  - Active sink consumes with no accept: hold_valid clears.
  - Both in the same cycle: hold reloads and stays valid.
- Output beat stability: once outN_valid=1, data and valid stay stable until outN_ready=1. Reset overrides this.
- RUN -> DRAIN: on frame_start=1 with sel_req != sel_active. sel_pend <= sel_req. An input beat accepted in that same cycle goes to the OLD destination.
- RUN with frame_start=1 and sel_req==sel_active: no state change.
- DRAIN:
  - in_ready=0, switching=1.
  - The held beat still drains to the old sink.
- DRAIN -> RUN: in the cycle where the slot is empty, or is being consumed (hold_valid=0 or active_ready=1). sel_active <= sel_pend at that transition. The first beat on the new sink can be accepted the following cycle.
- frame_start during DRAIN:
  - sel_pend re-sampled; latest request wins.
  - If the new sel_req == sel_active, return to RUN next cycle with no switch.
- Reset mid-DRAIN: the held beat is discarded and sel_active returns to SEL_INIT.
- frame_start while in_valid=0: handled identically.

Optional Feature:
- Macro: STREAM_DEMUX_SWITCH_CNT_EN.
- Defined:
  - Adds output port switch_cnt [15:0], reset to 0.
  - Increments on each DRAIN->RUN transition that changes sel_active.
  - Saturates at 16'hFFFF. Aborted drains are not counted.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package vga_stream_pkg:
  - typedef enum logic {RUN, DRAIN} demux_state_t.
  - localparam PIX_W_DEFAULT = 3.
  - localparam SWITCH_CNT_W = 16.
- Natural sub-module: stream_reg, a single-slot valid/ready pipeline register (WIDTH parameter).
- The FSM, routing and counter stay in the top module.

Test Plan:
- Reset, then in_valid=1, data 3'b101..3'b010, out0_ready=1:
  - data appears on out0 one cycle later, 1 beat/clk.
  - out1_valid stays 0 and out1_data stays 0.
- Backpressure: out0_ready=0 for 4 cycles with data 3'b110 held:
  - in_ready=0 and out0_data=3'b110 stable throughout.
  - The beat is released in the cycle out0_ready returns to 1.
- frame_start with sel_req=1 while hold_valid=1 and out0_ready=0 for 3 cycles:
  - switching=1 and in_ready=0 for those cycles.
  - The held beat exits on out0.
  - sel_active=1 afterward; the next beat goes to out1.
- frame_start sel_req=1, then a second frame_start sel_req=0 during DRAIN: returns to RUN with sel_active=0 and no switch. If STREAM_DEMUX_SWITCH_CNT_EN is defined, switch_cnt is unchanged.
- Assert reset mid-DRAIN with hold_valid=1: all valids drop immediately, sel_active=SEL_INIT, and the held beat never appears.
- STREAM_DEMUX_SWITCH_CNT_EN defined: 3 completed switches give switch_cnt=3; force the counter to 16'hFFFF, then one more switch leaves it at 16'hFFFF.
